pool_avg_ctrl: RTL and testbench
================================

# pool_avg_ctrl

Sequencer for the 2x2 average-pooling stage of the CNN accelerator. It scans an N×N feature map held in a single-port-read buffer, fetches each non-overlapping 2x2 window one pixel per cycle, and accumulates the four pixels at full precision. It writes floor(sum/4) for each window into an (N/2)×(N/2) output buffer in row-major order, then pulses `done`.

## Interface
Parameters:
- `DATA_W`, 16: pixel width, unsigned.
- `ADDR_W`, 16: buffer address width.
- `DIM_W`, 8: width of the image-dimension input.

Ports:
- `clk`, input, 1: single clock; all logic updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: one-cycle request; accepted only in IDLE.
- `img_n`, input, DIM_W: image side N; latched on accept.
- `in_base`, input, ADDR_W: address of input pixel (0,0); latched on accept.
- `out_base`, input, ADDR_W: address of output pixel (0,0); latched on accept.
- `rd_en`, output, 1: input-buffer read strobe.
- `rd_addr`, output, ADDR_W: read address.
- `rd_data`, input, DATA_W: read data; valid exactly 1 cycle after `rd_en`.
- `wr_en`, output, 1: output-buffer write strobe.
- `wr_addr`, output, ADDR_W: write address.
- `wr_data`, output, DATA_W: pooled pixel.
- `busy`, output, 1: high in RD, LAST and WR.
- `done`, output, 1: one-cycle pulse after the final write.

## Operation
- FSM states: IDLE, RD, LAST, WR, DONE.
  - IDLE: `start`=1 → latch config, clear the row/col counters and the accumulator, go to RD with `rd_cnt`=0.
  - RD: assert `rd_en` for 4 consecutive cycles. `rd_cnt` 0..3 gives addresses in this order:
    - in_base + r·N + c
    - +1
    - +N
    - +N+1
  - RD, `rd_cnt`=3 → LAST.
  - LAST: accumulate the 4th sample; no strobe.
  - WR: assert `wr_en`.
    - `wr_addr` = out_base + (r/2)·(N/2) + c/2.
    - `wr_data` = acc[DATA_W+1:2], i.e. floor(sum/4). The result never exceeds 2^DATA_W−1.
    - Clear acc and advance c by 2. At c = N−2, wrap c to 0 and advance r by 2.
    - Last window → DONE; otherwise → RD.
  - DONE: `done`=1 for one cycle, then IDLE.
- Accumulator: DATA_W+2 bits, no truncation. It adds `rd_data` on each cycle following a `rd_en`, so it captures the 4 samples in RD(1..3) and LAST.
- Effective N = `img_n` with bit 0 forced to 0, so odd sizes drop the last row and column.
  - Effective N = 0: IDLE → DONE directly, with no reads and no writes.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is not flagged.
- `start` in any state other than IDLE is ignored; it is not queued.
- Config inputs are don't-care after accept.
- Reset values: all outputs 0, FSM in IDLE, counters and acc 0.
  - `rst` mid-operation aborts the run: no write and no `done` that cycle; IDLE on the next cycle.
  - `rst` has priority over `start`.

## Timing
- `start` sampled in cycle t. Window k (k = 0..M−1, M = (N/2)²) has these cycles:
  - `rd_en` in cycles t+1+6k … t+4+6k.
  - LAST in t+5+6k.
  - `wr_en` in t+6+6k.
- `done` is in cycle t+6M+1; `busy` is high in t+1 … t+6M.
- Throughput is 6 cycles per output pixel, with no gaps between windows.
- `wr_en` and `rd_en` are never high in the same cycle.
- All outputs are registered, with no combinational path from inputs to outputs.
- The earliest re-accept of `start` is cycle t+6M+2.

## Structure
- Package `pool_pkg`:
  - state enum `pool_state_t` {IDLE, RD, LAST, WR, DONE};
  - localparams DATA_W, ADDR_W, ACC_W = DATA_W+2;
  - function `avg4(acc)` returning acc[ACC_W−1:2].
- Sub-module `pool_addr_gen`: row/col/rd_cnt counters, read/write address computation and the last-window flag; the FSM is the only client.
- The top module holds the FSM, the accumulator and the output registers.

## Test plan
- N=2, pixels 1,2,3,4 at in_base=0x10, out_base=0x80:
  - reads at 0x10, 0x11, 0x12, 0x13 in t+1..t+4;
  - a single write of 0x80 ← 2 at t+6;
  - `done` at t+7.
- N=4, input pixel value = address index 0..15:
  - writes out_base+0..3 = 2, 4, 10, 12 (floor(2.5), floor(4.5), floor(10.5), floor(12.5));
  - `done` at t+25.
- N=2, all pixels 0xFFFF → `wr_data`=0xFFFF, confirming no overflow truncation.
- N=4 run with `start` re-pulsed at t+3 and t+12 → still exactly 4 writes, one `done`, unchanged addresses.
- N=4 run with `rst` at t+9 → no `wr_en` from t+9 onward, no `done`, outputs 0 at t+10, `busy`=0; a fresh `start` then completes normally.
- `img_n`=0 → `done` at t+1, no strobes. `img_n`=5 → behaves as N=4: 4 writes, row stride 5 ignored in favour of stride 4.

Source files
------------

// File: rtl/pool_pkg.sv
// pool_pkg: shared types and helpers for the 2x2 average-pooling sequencer.
//   pool_state_t : sequencer FSM states
//   DATA_W/ADDR_W: default pixel and address widths
//   ACC_W        : accumulator width (four DATA_W samples without overflow)
//   avg4()       : floor(sum/4) of a four-sample accumulator
package pool_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int ACC_W  = DATA_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAST,
    WR,
    DONE
  } pool_state_t;

  // Dropping the two LSBs is floor(sum/4); the top DATA_W bits cannot
  // overflow because four DATA_W values fit in DATA_W+2 bits.
  function automatic logic [DATA_W-1:0] avg4(input logic [ACC_W-1:0] acc);
    return acc[ACC_W-1:2];
  endfunction

endpackage

// File: rtl/pool_avg_ctrl_if.sv
// pool_avg_ctrl_if: job request, input-buffer read port, output-buffer write
// port and status of the pooling sequencer.
//   master : sequencer side (drives strobes, addresses, pooled data, status)
//   slave  : host/buffer side (drives start, config and read data)
interface pool_avg_ctrl_if #(
  parameter int DATA_W = pool_pkg::DATA_W,
  parameter int ADDR_W = pool_pkg::ADDR_W,
  parameter int DIM_W  = 8
);
  logic              start;
  logic [DIM_W-1:0]  img_n;
  logic [ADDR_W-1:0] in_base;
  logic [ADDR_W-1:0] out_base;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, img_n, in_base, out_base, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    output start, img_n, in_base, out_base, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: window walker for the pooling sequencer.
//   init      : load N (already even), bases; clear row/col/rd_cnt
//   step_rd   : advance the sample index inside the current window (wraps 3->0)
//   step_win  : move to the next 2x2 window and the next output address
//   rd_cnt    : index of the sample being read this cycle
//   rd_addr_nxt  : address of sample rd_cnt+1 in the current window
//   win_base_nxt : address of sample 0 of the next window
//   wr_addr   : output address of the current window
//   last_win  : current window is the bottom-right one
// Window and output addresses are tracked incrementally, so no multiplier.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int ADDR_W = pool_pkg::ADDR_W,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              step_rd,
  input  logic              step_win,
  input  logic [DIM_W-1:0]  n_in,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic [1:0]        rd_cnt,
  output logic [ADDR_W-1:0] rd_addr_nxt,
  output logic [ADDR_W-1:0] win_base_nxt,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_win
);

  logic [DIM_W-1:0]  n_q;
  logic [DIM_W-1:0]  r_q;
  logic [DIM_W-1:0]  c_q;
  logic [DIM_W-1:0]  n_m2;
  logic [ADDR_W-1:0] n_a;
  logic [ADDR_W-1:0] win_base_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              col_wrap;

  assign n_m2     = n_q - DIM_W'(2);
  assign n_a      = ADDR_W'(n_q);
  assign col_wrap = (c_q == n_m2);
  assign last_win = col_wrap && (r_q == n_m2);
  assign wr_addr  = wr_ptr_q;

  // At the end of a row pair, window base jumps from r*N+N-2 to (r+2)*N.
  assign win_base_nxt = col_wrap ? (win_base_q + n_a + ADDR_W'(2))
                                 : (win_base_q + ADDR_W'(2));

  // Window sample order: (r,c), (r,c+1), (r+1,c), (r+1,c+1).
  always_comb begin
    rd_addr_nxt = win_base_q;
    case (rd_cnt)
      2'd0:    rd_addr_nxt = win_base_q + ADDR_W'(1);
      2'd1:    rd_addr_nxt = win_base_q + n_a;
      2'd2:    rd_addr_nxt = win_base_q + n_a + ADDR_W'(1);
      default: rd_addr_nxt = win_base_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      rd_cnt     <= '0;
      win_base_q <= '0;
      wr_ptr_q   <= '0;
    end else if (init) begin
      n_q        <= n_in;
      r_q        <= '0;
      c_q        <= '0;
      rd_cnt     <= '0;
      win_base_q <= in_base;
      wr_ptr_q   <= out_base;
    end else begin
      if (step_rd) begin
        rd_cnt <= rd_cnt + 2'd1;
      end
      if (step_win) begin
        win_base_q <= win_base_nxt;
        wr_ptr_q   <= wr_ptr_q + ADDR_W'(1);
        if (col_wrap) begin
          c_q <= '0;
          r_q <= r_q + DIM_W'(2);
        end else begin
          c_q <= c_q + DIM_W'(2);
        end
      end
    end
  end

endmodule

// File: rtl/pool_avg_ctrl.sv
// pool_avg_ctrl: 2x2 average-pooling sequencer.
// Scans an N x N map (N = img_n with bit 0 cleared) one window at a time,
// reading four pixels on consecutive cycles, summing them at full precision
// and writing floor(sum/4) row-major to the output buffer, then pulsing done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pool_avg_ctrl_if.master -- start/img_n/in_base/out_base request,
//              rd_en/rd_addr/rd_data read port (1-cycle latency),
//              wr_en/wr_addr/wr_data write port, busy/done status
// Every output is a flop loaded from the next-state decode, so an output
// value seen in a cycle belongs to the state held in that same cycle.
module pool_avg_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input logic clk,
  input logic rst,
  pool_avg_ctrl_if.master bus
);
  import pool_pkg::*;

  localparam int AW = DATA_W + 2;

  pool_state_t       state_q, state_d;

  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              vld_p1;
  logic [AW-1:0]     acc_q;
  logic [AW-1:0]     acc_sum;
  logic              acc_clr;

  logic              init, step_rd, step_win;
  logic [DIM_W-1:0]  n_even;
  logic              n_zero;
  logic [1:0]        rd_cnt;
  logic [ADDR_W-1:0] rd_addr_nxt, win_base_nxt, gen_wr_addr;
  logic              last_win;

  assign n_even  = {bus.img_n[DIM_W-1:1], 1'b0};
  assign n_zero  = (n_even == '0);
  assign acc_sum = acc_q + AW'(bus.rd_data);

  pool_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .init         (init),
    .step_rd      (step_rd),
    .step_win     (step_win),
    .n_in         (n_even),
    .in_base      (bus.in_base),
    .out_base     (bus.out_base),
    .rd_cnt       (rd_cnt),
    .rd_addr_nxt  (rd_addr_nxt),
    .win_base_nxt (win_base_nxt),
    .wr_addr      (gen_wr_addr),
    .last_win     (last_win)
  );

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    done_d    = 1'b0;
    init      = 1'b0;
    step_rd   = 1'b0;
    step_win  = 1'b0;
    acc_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          init    = 1'b1;
          acc_clr = 1'b1;
          if (n_zero) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = RD;
            rd_en_d   = 1'b1;
            rd_addr_d = bus.in_base;
          end
        end
      end
      RD: begin
        step_rd = 1'b1;
        if (rd_cnt == 2'd3) begin
          state_d = LAST;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_nxt;
        end
      end
      LAST: begin
        // The fourth sample arrives now; fold it straight into the result.
        state_d   = WR;
        wr_en_d   = 1'b1;
        wr_addr_d = gen_wr_addr;
        wr_data_d = avg4(acc_sum);
      end
      WR: begin
        step_win = 1'b1;
        acc_clr  = 1'b1;
        if (last_win) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d   = RD;
          rd_en_d   = 1'b1;
          rd_addr_d = win_base_nxt;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RD) || (state_d == LAST) || (state_d == WR);
  end

  // p0 -> p1: state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // p1 -> p2: read data returns one cycle after the strobe; accumulate it
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      acc_q  <= '0;
    end else begin
      vld_p1 <= rd_en_q;
      if (acc_clr) begin
        acc_q <= '0;
      end else if (vld_p1) begin
        acc_q <= acc_sum;
      end
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_pool_avg_ctrl.sv
// Directed bench for pool_avg_ctrl: strobes are logged with their cycle
// number on the falling edge and compared against hand-computed schedules.
module tb_pool_avg_ctrl;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pool_avg_ctrl_if #(.DATA_W(16), .ADDR_W(16), .DIM_W(8)) bus ();

  pool_avg_ctrl #(.DATA_W(16), .ADDR_W(16), .DIM_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [0:255];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];
  int  busy_n = 0;
  int  overlap_n = 0;

  // snapshot of log positions at job start
  int rd0, wr0, d0, b0, o0;

  always @(posedge clk) cyc <= cyc + 1;

  // input buffer: one-cycle read latency
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[7:0]];
  end

  always @(negedge clk) begin
    if (bus.rd_en) rd_q.push_back('{cyc, bus.rd_addr, 16'h0});
    if (bus.wr_en) wr_q.push_back('{cyc, bus.wr_addr, bus.wr_data});
    if (bus.done) done_q.push_back(cyc);
    if (bus.busy) busy_n++;
    if (bus.rd_en && bus.wr_en) overlap_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_job(input int n, input int ib, input int ob, output int t);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.img_n    = 8'(n);
    bus.in_base  = 16'(ib);
    bus.out_base = 16'(ob);
    t   = cyc;
    rd0 = rd_q.size();
    wr0 = wr_q.size();
    d0  = done_q.size();
    b0  = busy_n;
    o0  = overlap_n;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.img_n    = 8'hFF;
    bus.in_base  = 16'hDEAD;
    bus.out_base = 16'hBEEF;
  endtask

  task automatic chk_rd(input string tag, input int idx, input int ecyc, input int eaddr);
    if (rd0 + idx < rd_q.size()) begin
      chk({tag, "_cyc"}, rd_q[rd0+idx].cyc, ecyc);
      chk({tag, "_addr"}, {16'h0, rd_q[rd0+idx].addr}, eaddr);
    end else begin
      chk({tag, "_present"}, rd_q.size(), rd0 + idx + 1);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input int ecyc,
                        input int eaddr, input int edata);
    if (wr0 + idx < wr_q.size()) begin
      chk({tag, "_cyc"}, wr_q[wr0+idx].cyc, ecyc);
      chk({tag, "_addr"}, {16'h0, wr_q[wr0+idx].addr}, eaddr);
      chk({tag, "_data"}, {16'h0, wr_q[wr0+idx].data}, edata);
    end else begin
      chk({tag, "_present"}, wr_q.size(), wr0 + idx + 1);
    end
  endtask

  task automatic chk_done(input string tag, input int ecyc);
    chk({tag, "_done_cnt"}, done_q.size() - d0, 1);
    if (done_q.size() > d0) chk({tag, "_done_cyc"}, done_q[d0], ecyc);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_en"}, bus.rd_en, 0);
    chk({tag, "_rd_addr"}, bus.rd_addr, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  // 4x4 window sample offsets (stride 4) in read order
  int offs4 [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  int avg4x4 [4] = '{2, 4, 10, 12};

  initial begin
    int t;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'd1; mem[8'h11] = 16'd2; mem[8'h12] = 16'd3; mem[8'h13] = 16'd4;
    for (int i = 0; i < 16; i++) mem[8'h20 + i] = 16'(i);
    for (int i = 0; i < 4; i++) mem[8'h30 + i] = 16'hFFFF;

    bus.start = 1'b0; bus.img_n = '0; bus.in_base = '0; bus.out_base = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // N=2, pixels 1..4
    start_job(2, 'h10, 'h80, t);
    wait_until(t + 12);
    chk("n2_rd_cnt", rd_q.size() - rd0, 4);
    for (int j = 0; j < 4; j++) chk_rd($sformatf("n2_rd%0d", j), j, t + 1 + j, 'h10 + j);
    chk("n2_wr_cnt", wr_q.size() - wr0, 1);
    chk_wr("n2_wr", 0, t + 6, 'h80, 2);
    chk_done("n2", t + 7);
    chk("n2_busy_cycles", busy_n - b0, 6);

    // N=4, pixel = index
    start_job(4, 'h20, 'h40, t);
    wait_until(t + 30);
    chk("n4_rd_cnt", rd_q.size() - rd0, 16);
    for (int j = 0; j < 16; j++)
      chk_rd($sformatf("n4_rd%0d", j), j, t + 1 + 6*(j/4) + (j%4), 'h20 + offs4[j]);
    chk("n4_wr_cnt", wr_q.size() - wr0, 4);
    for (int k = 0; k < 4; k++)
      chk_wr($sformatf("n4_wr%0d", k), k, t + 6 + 6*k, 'h40 + k, avg4x4[k]);
    chk_done("n4", t + 25);
    chk("n4_busy_cycles", busy_n - b0, 24);
    chk("n4_rd_wr_overlap", overlap_n - o0, 0);

    // N=2 saturated pixels
    start_job(2, 'h30, 'h88, t);
    wait_until(t + 12);
    chk_wr("max_wr", 0, t + 6, 'h88, 'hFFFF);
    chk_done("max", t + 7);

    // N=4 with start re-pulsed mid-run
    start_job(4, 'h20, 'h40, t);
    wait_until(t + 3);
    bus.start = 1'b1; bus.img_n = 8'd2; bus.in_base = 16'h0099; bus.out_base = 16'h00C0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(t + 12);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(t + 30);
    chk("rep_wr_cnt", wr_q.size() - wr0, 4);
    for (int k = 0; k < 4; k++)
      chk_wr($sformatf("rep_wr%0d", k), k, t + 6 + 6*k, 'h40 + k, avg4x4[k]);
    chk_done("rep", t + 25);

    // N=4 aborted by reset at t+9
    start_job(4, 'h20, 'h40, t);
    wait_until(t + 9);
    rst = 1'b1;
    wait_until(t + 10);
    rst = 1'b0;
    chk_outputs_zero("abort");
    wait_until(t + 35);
    chk("abort_wr_cnt", wr_q.size() - wr0, 1);
    chk_wr("abort_wr", 0, t + 6, 'h40, 2);
    chk("abort_done_cnt", done_q.size() - d0, 0);

    // fresh run after the abort
    start_job(2, 'h10, 'h90, t);
    wait_until(t + 12);
    chk_wr("fresh_wr", 0, t + 6, 'h90, 2);
    chk_done("fresh", t + 7);

    // img_n = 0: immediate done, no strobes
    start_job(0, 'h10, 'h80, t);
    wait_until(t + 6);
    chk("n0_rd_cnt", rd_q.size() - rd0, 0);
    chk("n0_wr_cnt", wr_q.size() - wr0, 0);
    chk_done("n0", t + 1);
    chk("n0_busy_cycles", busy_n - b0, 0);

    // img_n = 5 behaves as N=4
    start_job(5, 'h20, 'h50, t);
    wait_until(t + 30);
    chk("n5_rd_cnt", rd_q.size() - rd0, 16);
    chk_rd("n5_rd6", 6, t + 9, 'h26);
    chk_rd("n5_rd10", 10, t + 15, 'h2C);
    chk("n5_wr_cnt", wr_q.size() - wr0, 4);
    for (int k = 0; k < 4; k++)
      chk_wr($sformatf("n5_wr%0d", k), k, t + 6 + 6*k, 'h50 + k, avg4x4[k]);
    chk_done("n5", t + 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
